// File: rtl/pir_display_driver.sv
// pir_display_driver: snapshots the PIR status word, converts the peak reading to BCD
// with a serial double-dabble FSM and scans five active-low seven-segment digits.
module pir_display_driver #(
  parameter int SCAN_DIV  = 4,
  parameter int BLINK_DIV = 50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [20:0] display_data,
  input  logic        buzzer,
  output logic [6:0]  seg_n,
  output logic [4:0]  an_n,
  output logic        dp_n,
  output logic        bcd_busy
);
  localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [6:0]    SEG_BLANK  = 7'h7F;

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;
  state_t state, state_next;

  logic [15:0]   snap;
  logic [7:0]    bin_sr;
  logic [9:0]    bcd_sr, bcd_adj;
  logic [2:0]    bit_cnt;
  logic [3:0]    disp_cnt, disp_id, disp_t, disp_o;
  logic [1:0]    disp_h;
  logic          changed;
  logic [SW-1:0] pre, pre_next;
  logic [2:0]    idx, idx_next;
  logic [BW-1:0] blink_cnt;
  logic          blink;
  logic [6:0]    digit_seg;
  logic [4:0]    unused_bits;

  assign unused_bits = display_data[20:16];
  assign dp_n        = 1'b1;
  assign changed     = (display_data[15:0] != snap);

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h06;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (changed) state_next = SHIFT;
      SHIFT:   if (bit_cnt == 3'd7) state_next = LOAD;
      LOAD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Hundreds only ever reaches 2, so only the tens and ones nibbles need the +3 correction
  always_comb begin
    bcd_adj = bcd_sr;
    if (bcd_sr[3:0] >= 4'd5) bcd_adj[3:0] = bcd_sr[3:0] + 4'd3;
    if (bcd_sr[7:4] >= 4'd5) bcd_adj[7:4] = bcd_sr[7:4] + 4'd3;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap     <= '0;
      bin_sr   <= '0;
      bcd_sr   <= '0;
      bit_cnt  <= '0;
      bcd_busy <= 1'b0;
      disp_cnt <= '0;
      disp_id  <= '0;
      disp_h   <= '0;
      disp_t   <= '0;
      disp_o   <= '0;
    end else begin
      case (state)
        IDLE: if (changed) begin
          snap     <= display_data[15:0];
          bin_sr   <= display_data[11:4];
          bcd_sr   <= '0;
          bit_cnt  <= '0;
          bcd_busy <= 1'b1;
        end
        SHIFT: begin
          bcd_sr  <= {bcd_adj[8:0], bin_sr[7]};
          bin_sr  <= {bin_sr[6:0], 1'b0};
          bit_cnt <= bit_cnt + 3'd1;
        end
        LOAD: begin
          disp_cnt <= snap[3:0];
          disp_id  <= snap[15:12];
          disp_h   <= bcd_sr[9:8];
          disp_t   <= bcd_sr[7:4];
          disp_o   <= bcd_sr[3:0];
          bcd_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    pre_next = pre + SW'(1);
    idx_next = idx;
    if (pre == SCAN_LAST) begin
      pre_next = '0;
      idx_next = (idx == 3'd4) ? 3'd0 : idx + 3'd1;
    end
  end

  // Leading-zero suppression on the peak: tens is blank only when hundreds is blank too
  always_comb begin
    digit_seg = SEG_BLANK;
    case (idx_next)
      3'd0:    digit_seg = seg7(disp_cnt);
      3'd1:    digit_seg = seg7(disp_id);
      3'd2:    if (disp_h != 2'd0) digit_seg = seg7({2'b00, disp_h});
      3'd3:    if (disp_h != 2'd0 || disp_t != 4'd0) digit_seg = seg7(disp_t);
      3'd4:    digit_seg = seg7(disp_o);
      default: digit_seg = SEG_BLANK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (!buzzer) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blink     <= ~blink;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  // Segments use the blink flag as it stood before this edge, so clearing buzzer
  // restores normal segments one edge later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre   <= '0;
      idx   <= '0;
      an_n  <= 5'h1F;
      seg_n <= SEG_BLANK;
    end else begin
      pre   <= pre_next;
      idx   <= idx_next;
      an_n  <= ~(5'd1 << idx_next);
      seg_n <= blink ? SEG_BLANK : digit_seg;
    end
  end
endmodule
